// File: rtl/asansor_denetleyici.sv
// Eight-floor elevator cab controller.
// Latches floor calls into a pending mask, moves the cab with a SCAN
// (continue-in-direction) policy and times travel/door intervals with one
// shared down-to-zero-free up-counter. All outputs come straight from flops.
module asansor_denetleyici #(
    parameter int TRAVEL = 4,   // cycles per floor of travel
    parameter int DOOR   = 6    // cycles the door stays open
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] istek,
    output logic [2:0] kat,
    output logic [7:0] bekleyen,
    output logic       yukari,
    output logic       asagi,
    output logic       kapi_acik,
    output logic       mesgul
);

    localparam int MAXT = (TRAVEL > DOOR) ? TRAVEL : DOOR;
    localparam int TW   = (MAXT <= 1) ? 1 : $clog2(MAXT);
    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL - 1);
    localparam logic [TW-1:0] D_LAST = TW'(DOOR - 1);

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HAREKET = 2'd1,
        KAPI    = 2'd2
    } durum_t;

    durum_t        r_durum;
    logic [2:0]    r_kat;
    logic          r_yon;       // 1 = up
    logic [7:0]    r_pend;
    logic [TW-1:0] r_t;
    logic          r_yukari;
    logic          r_asagi;
    logic          r_kapi;
    logic          r_mesgul;

    logic [2:0]    w_kat_sonraki;   // floor reached at the end of this travel interval
    logic [7:0]    w_ust;           // pending floors above the current floor
    logic [7:0]    w_alt;           // pending floors below the current floor
    logic [7:0]    w_ust_s;         // pending floors above the next floor
    logic [7:0]    w_alt_s;         // pending floors below the next floor
    logic          w_above;
    logic          w_below;
    logic          w_ileri_s;       // requests still ahead once the next floor is reached
    logic          w_varis;         // last cycle of a travel interval
    logic [7:0]    w_clr;
    logic [7:0]    w_pend_next;

    assign w_kat_sonraki = r_yon ? (r_kat + 3'd1) : (r_kat - 3'd1);
    assign w_varis       = (r_durum == HAREKET) && (r_t == T_LAST);

    // Per-floor comparisons of the pending mask against current and next floor.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_kat
            localparam logic [2:0] KI = 3'(gi);
            assign w_ust[gi]   = r_pend[gi] && (KI > r_kat);
            assign w_alt[gi]   = r_pend[gi] && (KI < r_kat);
            assign w_ust_s[gi] = r_pend[gi] && (KI > w_kat_sonraki);
            assign w_alt_s[gi] = r_pend[gi] && (KI < w_kat_sonraki);
        end
    endgenerate

    assign w_above   = |w_ust;
    assign w_below   = |w_alt;
    assign w_ileri_s = r_yon ? (|w_ust_s) : (|w_alt_s);

    // Clear mask: the floor being served on entry to the door state, and the
    // cab's own floor for the whole door interval (so a call there is dropped).
    always_comb begin
        w_clr = '0;
        if (r_durum == BOSTA && r_pend[r_kat]) begin
            w_clr[r_kat] = 1'b1;
        end else if (w_varis && r_pend[w_kat_sonraki]) begin
            w_clr[w_kat_sonraki] = 1'b1;
        end
        if (r_durum == KAPI) begin
            w_clr[r_kat] = 1'b1;
        end
    end

    assign w_pend_next = (r_pend | istek) & ~w_clr;

    // Cab state machine, pending mask and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum  <= BOSTA;
            r_kat    <= 3'd0;
            r_yon    <= 1'b1;
            r_pend   <= 8'd0;
            r_t      <= '0;
            r_yukari <= 1'b0;
            r_asagi  <= 1'b0;
            r_kapi   <= 1'b0;
            r_mesgul <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            case (r_durum)
                BOSTA: begin
                    r_t <= '0;
                    if (r_pend[r_kat]) begin
                        r_durum  <= KAPI;
                        r_kapi   <= 1'b1;
                        r_mesgul <= 1'b1;
                    end else if (r_yon ? w_above : w_below) begin
                        r_durum  <= HAREKET;
                        r_yukari <= r_yon;
                        r_asagi  <= ~r_yon;
                        r_mesgul <= 1'b1;
                    end else if (r_yon ? w_below : w_above) begin
                        r_durum  <= HAREKET;
                        r_yon    <= ~r_yon;
                        r_yukari <= ~r_yon;
                        r_asagi  <= r_yon;
                        r_mesgul <= 1'b1;
                    end
                end
                HAREKET: begin
                    if (r_t == T_LAST) begin
                        r_kat <= w_kat_sonraki;
                        r_t   <= '0;
                        if (r_pend[w_kat_sonraki]) begin
                            r_durum  <= KAPI;
                            r_yukari <= 1'b0;
                            r_asagi  <= 1'b0;
                            r_kapi   <= 1'b1;
                        end else if (!w_ileri_s) begin
                            r_durum  <= BOSTA;
                            r_yukari <= 1'b0;
                            r_asagi  <= 1'b0;
                            r_mesgul <= 1'b0;
                        end
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
                KAPI: begin
                    if (r_t == D_LAST) begin
                        r_durum  <= BOSTA;
                        r_t      <= '0;
                        r_kapi   <= 1'b0;
                        r_mesgul <= 1'b0;
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
                default: begin
                    r_durum  <= BOSTA;
                    r_t      <= '0;
                    r_yukari <= 1'b0;
                    r_asagi  <= 1'b0;
                    r_kapi   <= 1'b0;
                    r_mesgul <= 1'b0;
                end
            endcase
        end
    end

    assign kat       = r_kat;
    assign bekleyen  = r_pend;
    assign yukari    = r_yukari;
    assign asagi     = r_asagi;
    assign kapi_acik = r_kapi;
    assign mesgul    = r_mesgul;

endmodule

// File: tb/tb_asansor_denetleyici.sv
// Bench for asansor_denetleyici: directed test-plan scenarios plus random
// calls, with a deadline-based behavioural cab model feeding a per-cycle
// expectation queue that an independent monitor drains and compares.
module tb_asansor_denetleyici;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 6;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] istek = 8'h00;
    logic [2:0] kat;
    logic [7:0] bekleyen;
    logic       yukari;
    logic       asagi;
    logic       kapi_acik;
    logic       mesgul;

    int n_tests = 0;
    int n_fail  = 0;

    asansor_denetleyici #(.TRAVEL(TRAVEL), .DOOR(DOOR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .istek     (istek),
        .kat       (kat),
        .bekleyen  (bekleyen),
        .yukari    (yukari),
        .asagi     (asagi),
        .kapi_acik (kapi_acik),
        .mesgul    (mesgul)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] kat;
        logic [7:0] bek;
        logic [3:0] flags;   // {up, down, door, busy}
    } snap_t;

    snap_t      exp_q[$];
    int         m_floor;
    bit         m_up;
    int         m_mode;
    longint     m_cycle;
    longint     m_deadline;
    bit [7:0]   m_pend;

    function automatic bit req_above(int f);
        for (int i = f + 1; i < 8; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_below(int f);
        for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_up = 1'b1; m_mode = M_IDLE;
        m_deadline = 0; m_pend = 8'h00;
    endtask

    // One clock edge of the cab, decided from the pending set as it stood before the edge.
    task automatic model_edge(input logic [7:0] req);
        bit [7:0] clr;
        bit [7:0] req_eff;
        snap_t s;
        m_cycle++;
        clr = 8'h00;
        req_eff = req;
        if (m_mode == M_DOOR) req_eff[m_floor] = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_mode = M_DOOR; m_deadline = m_cycle + DOOR; clr[m_floor] = 1'b1;
                end else if (m_up ? req_above(m_floor) : req_below(m_floor)) begin
                    m_mode = M_MOVE; m_deadline = m_cycle + TRAVEL;
                end else if (m_up ? req_below(m_floor) : req_above(m_floor)) begin
                    m_up = !m_up; m_mode = M_MOVE; m_deadline = m_cycle + TRAVEL;
                end
            end
            M_MOVE: begin
                if (m_cycle == m_deadline) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR; m_deadline = m_cycle + DOOR; clr[m_floor] = 1'b1;
                    end else if (m_up ? req_above(m_floor) : req_below(m_floor)) begin
                        m_deadline = m_cycle + TRAVEL;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                if (m_cycle == m_deadline) m_mode = M_IDLE;
            end
        endcase
        m_pend = (m_pend | req_eff) & ~clr;
        s.kat   = 3'(m_floor);
        s.bek   = m_pend;
        s.flags = {m_mode == M_MOVE && m_up, m_mode == M_MOVE && !m_up,
                   m_mode == M_DOOR, m_mode != M_IDLE};
        exp_q.push_back(s);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per active edge and compares it to the DUT.
    logic prev_kapi = 1'b0;
    always @(posedge clk) begin
        snap_t s;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            s = exp_q.pop_front();
            chk("kat", {5'd0, kat}, {5'd0, s.kat});
            chk("bekleyen", bekleyen, s.bek);
            chk("flags", {4'd0, yukari, asagi, kapi_acik, mesgul}, {4'd0, s.flags});
            if (kapi_acik && !prev_kapi)
                $display("[TB] door opens at floor %0d, pending %02h", kat, bekleyen);
        end
        prev_kapi = kapi_acik;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] req);
        istek = req;
        model_edge(req);
    endtask

    task automatic step(input logic [7:0] req);
        @(negedge clk);
        drive(req);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_mode == M_IDLE && m_pend == 8'h00) begin ok = 1'b1; break; end
            step(8'h00);
        end
        chk("idle reached", {7'd0, ok}, 8'd1);
    endtask

    task automatic step_until(input int f, input int mode);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_floor == f && m_mode == mode) begin ok = 1'b1; break; end
            step(8'h00);
        end
        chk("floor reached", {7'd0, ok}, 8'd1);
    endtask

    task automatic goto_floor(input int f);
        step(8'(1 << f));
        wait_idle();
    endtask

    task automatic check_reset_outputs();
        chk("rst kat", {5'd0, kat}, 8'd0);
        chk("rst bekleyen", bekleyen, 8'd0);
        chk("rst flags", {4'd0, yukari, asagi, kapi_acik, mesgul}, 8'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(8'h00);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs();
        repeat (3) @(negedge clk);
        release_reset();

        // Local call at floor 0.
        step(8'h01);
        wait_idle();
        // Single trip 0 -> 3.
        step(8'h08);
        wait_idle();
        // SCAN ordering: call 6, then 1 and 4 while passing floor 2 upward.
        goto_floor(0);
        step(8'h40);
        step_until(2, M_MOVE);
        step(8'h12);
        wait_idle();
        // Door at floor 2: repeated calls for floor 2 are dropped.
        goto_floor(2);
        step(8'h04);
        step(8'h00);
        step(8'h04);
        step(8'h04);
        wait_idle();
        // Pass-through and just-left floor.
        goto_floor(0);
        step(8'h20);
        step(8'h04);
        step_until(2, M_DOOR);
        step(8'h02);
        wait_idle();
        // Asynchronous reset mid-move at floor 3 going up.
        goto_floor(0);
        step(8'h80);
        step_until(3, M_MOVE);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        repeat (2) @(negedge clk);
        release_reset();
        step(8'h00);
        // All calls from floor 0.
        step(8'hFF);
        wait_idle();
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [7:0] req;
            r = int'($urandom_range(0, 15));
            if (r == 0)      req = 8'($urandom);
            else if (r < 4)  req = 8'(1 << $urandom_range(0, 7));
            else             req = 8'h00;
            step(req);
        end
        wait_idle();
        @(posedge clk);
        #3;
        chk("queue drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
